// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification for the sequential ALU.
// Optional ALU_SEQ_SRA_EN turns code 011 into an iterative arithmetic right shift.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SRA = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // Ops that go through the iterative shifter rather than the one-cycle core.
    function automatic logic is_shift(input logic [2:0] code);
`ifdef ALU_SEQ_SRA_EN
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
`else
        return (code == ALU_SLL) || (code == ALU_SRL);
`endif
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ADD/SUB/logic datapath with signed less-than for SUB.
// Any code it does not recognise (including 011 without SRA support) resolves to ADD.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      code,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res_c,
    output logic            lt_c
);

    logic [XLEN-1:0] diff;
    logic            ovf;

    assign diff = a - b;
    assign ovf  = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);

    always_comb begin
        res_c = a + b;
        lt_c  = 1'b0;
        case (code)
            ALU_SUB: begin
                res_c = diff;
                lt_c  = diff[XLEN-1] ^ ovf;
            end
            ALU_XOR: res_c = a ^ b;
            ALU_OR:  res_c = a | b;
            ALU_AND: res_c = a & b;
            default: res_c = a + b;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: one-cycle arithmetic/logic, bit-serial shifts, valid/ready in and out.
// Build with ALU_SEQ_SRA_EN to execute code 011 as SRA; otherwise 011 is ADD.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ALU_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    alu_state_e       state;
    logic [2:0]       code_q;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  acc_nxt;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]  core_res;
    logic             core_lt;

    assign shamt = op_b[SHAMT_W-1:0];

    alu_comb_core #(.XLEN(XLEN)) u_core (
        .code  (ALU_control),
        .a     (op_a),
        .b     (op_b),
        .res_c (core_res),
        .lt_c  (core_lt)
    );

    // One-bit step of the shift accumulator, direction chosen by the latched code.
    always_comb begin
        acc_nxt = {acc[XLEN-2:0], 1'b0};
        case (code_q)
            ALU_SRL: acc_nxt = {1'b0, acc[XLEN-1:1]};
`ifdef ALU_SEQ_SRA_EN
            ALU_SRA: acc_nxt = {acc[XLEN-1], acc[XLEN-1:1]};
`endif
            default: acc_nxt = {acc[XLEN-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            code_q    <= ALU_ADD;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            lt        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        code_q   <= ALU_control;
                        in_ready <= 1'b0;
                        if (!is_shift(ALU_control)) begin
                            result    <= core_res;
                            zero      <= (core_res == '0);
                            lt        <= core_lt;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (shamt == '0) begin
                            result    <= op_a;
                            zero      <= (op_a == '0);
                            lt        <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            acc   <= op_a;
                            cnt   <= shamt;
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc <= acc_nxt;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        result    <= acc_nxt;
                        zero      <= (acc_nxt == '0);
                        lt        <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed cases, random ops, backpressure and mid-shift reset.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        lt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        l;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALU_control (alu_ctl),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .lt          (lt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_shift(input logic [2:0] c);
`ifdef ALU_SEQ_SRA_EN
        return c == 3'b001 || c == 3'b101 || c == 3'b011;
`else
        return c == 3'b001 || c == 3'b101;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b010: return a - b;
            3'b100: return a ^ b;
            3'b110: return a | b;
            3'b111: return a & b;
            3'b001: return a << b[4:0];
            3'b101: return a >> b[4:0];
`ifdef ALU_SEQ_SRA_EN
            3'b011: return 32'($signed(a) >>> b[4:0]);
`endif
            default: return a + b;
        endcase
    endfunction

    // Present one request for one cycle and push its expectation.
    task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic el, input int elat);
        exp_t e;
        int   w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_send", 64'(in_ready), 64'(1));
        e.res = er;
        e.z   = (er == 32'h0);
        e.l   = el;
        e.lat = elat;
        sb.push_back(e);
        alu_ctl  = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, compare against the scoreboard head, optionally hold backpressure.
    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   lat;
        logic [31:0] r0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, 64'(lat), 64'(e.lat));
            check({tag, "_res"}, 64'(result), 64'(e.res));
            check({tag, "_zero"}, 64'(zero), 64'(e.z));
            check({tag, "_lt"}, 64'(lt), 64'(e.l));
        end
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            alu_ctl  = 3'b000;
            op_a     = 32'h1234;
            op_b     = 32'h1;
            @(posedge clk); #1;
            check({tag, "_hold_res"}, 64'(result), 64'(r0));
            check({tag, "_hold_inrdy"}, 64'(in_ready), 64'(0));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_idle_inrdy"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        int          stale;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctl   = 3'b000;
        op_a      = 32'h0;
        op_b      = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));
        check("rst_lt", 64'(lt), 64'(0));
        rst_n = 1'b1;
        check("rst_inrdy", 64'(in_ready), 64'(1));

        send(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
        collect("add_ovf", 0);
        send(3'b010, 32'd5, 32'd5, 32'h0, 1'b0, 1);
        collect("sub_eq", 0);
        send(3'b010, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1);
        collect("sub_lt", 0);
        send(3'b001, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32);
        collect("sll31", 0);
        send(3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 5);
        collect("srl4", 0);
        send(3'b001, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
        collect("sll0", 0);
        send(3'b111, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 1'b0, 1);
        collect("and_zero", 0);
`ifdef ALU_SEQ_SRA_EN
        send(3'b011, 32'hF000_0000, 32'd4, 32'hFF00_0000, 1'b0, 5);
`else
        send(3'b011, 32'hF000_0000, 32'd4, 32'hF000_0004, 1'b0, 1);
`endif
        collect("code011", 0);

        send(3'b110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1);
        collect("bp_or", 10);
        send(3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);
        collect("after_bp", 0);

        for (int k = 0; k < 10; k++) begin
            c  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (model_shift(c)) b = 32'($urandom_range(0, 12));
            er = model(c, a, b);
            send(c, a, b, er, (c == 3'b010) ? ($signed(a) < $signed(b)) : 1'b0,
                 (model_shift(c) && b[4:0] != 5'd0) ? 1 + int'(b[4:0]) : 1);
            collect("rand", k % 3);
        end

        // Abort a long shift with reset after 8 cycles in flight.
        alu_ctl  = 3'b001;
        op_a     = 32'h1;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midshift_busy", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        rst_n = 1'b1;
        check("midrst_inrdy", 64'(in_ready), 64'(1));
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("midrst_no_stale", 64'(stale), 64'(0));

        send(3'b000, 32'd100, 32'd23, 32'd123, 1'b0, 1);
        collect("post_rst_add", 0);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
